// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_pkg
//  Brief    : Shared types and constants for the 5-stage core control path.
//  Revision : 1.0  initial release
// ============================================================================
package core_pkg;

    // Pipeline sequencing controller states
    typedef enum logic [0:0] {
        CTRL_RUN      = 1'b0,
        CTRL_MEM_WAIT = 1'b1
    } ctrl_state_e;

    // Architectural zero register; a load to x0 never creates a hazard
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : core_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_detect
//  Brief    : Combinational load-use hazard compare between ID and ID/EX.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_detect
    import core_pkg::*;
(
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_uses_rs1,
    input  logic       i_uses_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    // A load in EX whose (non-zero) destination is read by the ID instruction
    always_comb begin
        w_rs1_hit  = i_uses_rs1 && (i_ex_rd == i_rs1);
        w_rs2_hit  = i_uses_rs2 && (i_ex_rd == i_rs2);
        o_load_use = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline sequencing controller: load-use stalls, taken-branch
//             flushes, data-memory wait freezes, perf counters, mem timeout.
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int                  c_wait_w   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MEM_TIMEOUT);

    ctrl_state_e         r_state;
    ctrl_state_e         w_state_nxt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_wait_w-1:0] w_wait_inc;
    logic                w_load_use;
    logic                w_freeze;
    logic                w_branch;
    logic                w_lu_stall;

    hazard_detect u_hazard_detect (
        .i_rs1         (if_id_rs1),
        .i_rs2         (if_id_rs2),
        .i_uses_rs1    (id_uses_rs1),
        .i_uses_rs2    (id_uses_rs2),
        .i_ex_rd       (id_ex_rd),
        .i_ex_mem_read (id_ex_mem_read),
        .o_load_use    (w_load_use)
    );

    // Hazard classification; a ready in MEM_WAIT releases the freeze at once
    always_comb begin
        w_freeze   = ((r_state == CTRL_MEM_WAIT) || dmem_req) && !dmem_ready;
        w_branch   = ex_branch_taken && !w_freeze;
        // A branch squashes the ID instruction, so its load-use is moot
        w_lu_stall = w_load_use && !w_freeze && !ex_branch_taken;
        w_wait_inc = (r_wait_cnt == c_wait_max) ? c_wait_max : r_wait_cnt + 1'b1;
    end

    // Next-state and pipeline control outputs, priority freeze > branch > load-use
    always_comb begin
        w_state_nxt   = r_state;
        pc_write      = 1'b0;
        pc_sel_branch = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_write  = 1'b0;

        case (r_state)
            CTRL_RUN:      if (dmem_req && !dmem_ready) w_state_nxt = CTRL_MEM_WAIT;
            CTRL_MEM_WAIT: if (dmem_ready)              w_state_nxt = CTRL_RUN;
            default:                                    w_state_nxt = CTRL_RUN;
        endcase

        if (rst || w_freeze) begin
            // everything held
        end else if (w_branch) begin
            pc_write      = 1'b1;
            pc_sel_branch = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_write   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_write  = 1'b1;
            mem_wb_write  = 1'b1;
        end else if (w_lu_stall) begin
            // hold PC and IF/ID, inject one bubble into ID/EX
            id_ex_write   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_write  = 1'b1;
            mem_wb_write  = 1'b1;
        end else begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            mem_wb_write  = 1'b1;
        end
    end

    // State register plus memory-wait watchdog with sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CTRL_RUN;
            r_wait_cnt <= '0;
            mem_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CTRL_RUN && w_state_nxt == CTRL_MEM_WAIT) begin
                r_wait_cnt <= '0;
            end else if (r_state == CTRL_MEM_WAIT) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == c_wait_max) mem_err <= 1'b1;
            end
        end
    end

    // Performance counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_freeze || w_lu_stall) stall_cnt <= stall_cnt + 1'b1;
            if (w_branch)               flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 32;

    // Control vector {pc_write, pc_sel_branch, if_id_write, if_id_flush,
    //                 id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write}
    localparam logic [7:0] C_HOLD   = 8'b0000_0000;
    localparam logic [7:0] C_NORMAL = 8'b1010_1011;
    localparam logic [7:0] C_BRANCH = 8'b1111_1111;
    localparam logic [7:0] C_LDUSE  = 8'b0000_1111;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_rs1, if_id_rs2, id_ex_rd;
    logic             id_uses_rs1, id_uses_rs2, id_ex_mem_read;
    logic             ex_branch_taken, dmem_req, dmem_ready;
    logic             pc_write, pc_sel_branch, if_id_write, if_id_flush;
    logic             id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_err;
    logic [7:0]       ctrl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign ctrl = {pc_write, pc_sel_branch, if_id_write, if_id_flush,
                   id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write};

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_ex_rd        (id_ex_rd),
        .id_ex_mem_read  (id_ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .pc_sel_branch   (pc_sel_branch),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_write     (id_ex_write),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_write    (mem_wb_write),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .mem_err         (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_id_rs1 = 5'd0; if_id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_ex_rd = 5'd0; id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        check("rst_ctrl",  32'(ctrl), 32'(C_HOLD));
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        check("rst_err",   32'(mem_err), 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("normal_idle", 32'(ctrl), 32'(C_NORMAL));

        // Load-use: ld x5 in EX, add x6,x5,x1 in ID
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd5;
        if_id_rs1 = 5'd5; if_id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
        #1 check("lu_stall", 32'(ctrl), 32'(C_LDUSE));
        tick();
        id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;   // bubble now in EX
        #1 check("lu_after", 32'(ctrl), 32'(C_NORMAL));
        check("lu_stall_cnt", stall_cnt, 1);

        // Load to x0 is never a hazard
        id_ex_mem_read = 1'b1; id_ex_rd = 5'd0; if_id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1 check("x0_load", 32'(ctrl), 32'(C_NORMAL));
        tick();
        check("x0_stall_cnt", stall_cnt, 1);

        // rs2 match only counts when rs2 is used
        id_ex_rd = 5'd7; if_id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
        if_id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
        #1 check("unused_match", 32'(ctrl), 32'(C_NORMAL));
        id_uses_rs2 = 1'b1;
        #1 check("rs2_lu", 32'(ctrl), 32'(C_LDUSE));
        tick();
        check("rs2_stall_cnt", stall_cnt, 2);

        // Branch and load-use together: branch wins, no stall counted
        id_ex_rd = 5'd5; if_id_rs1 = 5'd5; id_uses_rs1 = 1'b1; ex_branch_taken = 1'b1;
        #1 check("br_lu", 32'(ctrl), 32'(C_BRANCH));
        tick();
        idle_inputs();
        #1 check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);

        // Memory wait: ready low 3 cycles, high on the 4th
        dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("mw_hold%0d", i), 32'(ctrl), 32'(C_HOLD));
            tick();
        end
        dmem_ready = 1'b1;
        #1 check("mw_release", 32'(ctrl), 32'(C_NORMAL));
        tick();
        check("mw_stall_cnt", stall_cnt, 5);
        // Hit in the same cycle: stays RUN
        dmem_req = 1'b1; dmem_ready = 1'b1;
        #1 check("hit_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();
        dmem_req = 1'b0; dmem_ready = 1'b0;
        #1 check("hit_run", 32'(ctrl), 32'(C_NORMAL));
        check("hit_stall_cnt", stall_cnt, 5);

        // Branch pending during freeze: redirect only once memory is ready
        dmem_req = 1'b1; ex_branch_taken = 1'b1;
        #1 check("brf_hold0", 32'(ctrl), 32'(C_HOLD));
        tick();
        #1 check("brf_hold1", 32'(ctrl), 32'(C_HOLD));
        check("brf_flush_wait", flush_cnt, 1);
        tick();
        dmem_ready = 1'b1;
        #1 check("brf_fire", 32'(ctrl), 32'(C_BRANCH));
        tick();
        idle_inputs();
        #1 check("brf_after", 32'(ctrl), 32'(C_NORMAL));
        check("brf_flush_cnt", flush_cnt, 2);
        check("brf_stall_cnt", stall_cnt, 7);
        tick();
        check("brf_flush_once", flush_cnt, 2);

        // Timeout with MEM_TIMEOUT=4: RUN cycle, then 4 MEM_WAIT cycles
        dmem_req = 1'b1;
        tick();               // RUN -> MEM_WAIT
        tick(); tick(); tick();
        check("to_err_early", 32'(mem_err), 0);
        tick();
        check("to_err_set", 32'(mem_err), 1);
        check("to_stall_cnt", stall_cnt, 12);
        tick(); tick();
        check("to_err_sticky", 32'(mem_err), 1);
        check("to_ctrl_hold", 32'(ctrl), 32'(C_HOLD));

        // Asynchronous reset mid-wait
        #2 rst = 1'b1;
        #1 check("to_rst_err", 32'(mem_err), 0);
        check("to_rst_stall", stall_cnt, 0);
        check("to_rst_ctrl", 32'(ctrl), 32'(C_HOLD));
        idle_inputs();
        tick();
        rst = 1'b0;
        #1 check("to_rst_run", 32'(ctrl), 32'(C_NORMAL));
        tick();
        check("to_rst_err2", 32'(mem_err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
